sa_controller: RTL and testbench

- Sequencer for the systolic array of PE cells (N-bit F/W operands, 2N-bit accumulators P).
- Runs one tile: clears the accumulators (Sclr), loads weights row by row, and streams K feature vectors with compute_SA asserted.
- Flushes the array skew, then drains the accumulated rows through a valid/ready handshake.
- Sits between the top-level layer scheduler (start/done) and the array plus its feature/weight buffers.

---
 rtl/sa_controller_if.sv | 35 +++
 rtl/sa_controller.sv | 176 +++++++++++++++++
 tb/tb_sa_controller.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/sa_controller_if.sv
// Scheduler/array-side signal bundle for sa_controller: tile request, array
// control strobes and the drained-row valid/ready handshake.
interface sa_controller_if #(
   parameter int ROWS = 4,
   parameter int KW   = 8
);
   localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

   logic          start;
   logic [KW-1:0] k_len;
   logic          pause;
   logic          out_ready;
   logic          busy;
   logic          done;
   logic          sclr;
   logic          compute_sa;
   logic          w_load;
   logic [RW-1:0] w_row_sel;
   logic          f_rd_en;
   logic [KW-1:0] f_rd_addr;
   logic          out_valid;
   logic [RW-1:0] out_row;

   modport master (
      output start, k_len, pause, out_ready,
      input  busy, done, sclr, compute_sa, w_load, w_row_sel,
             f_rd_en, f_rd_addr, out_valid, out_row
   );

   modport slave (
      input  start, k_len, pause, out_ready,
      output busy, done, sclr, compute_sa, w_load, w_row_sel,
             f_rd_en, f_rd_addr, out_valid, out_row
   );
endinterface

// File: rtl/sa_controller.sv
// Tile sequencer for the systolic array: clear, weight load, feature feed,
// skew flush, row drain, done. Optional freeze in FEED/FLUSH under SA_PAUSE_EN.
module sa_controller #(
   parameter int ROWS = 4,
   parameter int COLS = 4,
   parameter int KW   = 8
) (
   input  logic                Clk,
   input  logic                Rst_n,
   sa_controller_if.slave      bus,
   output logic [2:0]          dbg_state_o
);
   localparam int RW        = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int FLUSH_LEN = ROWS + COLS - 2;
   localparam int SW        = $clog2(ROWS + COLS);
   localparam int CW        = (KW > SW) ? KW : SW;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_CLEAR  = 3'd1,
      S_LOAD_W = 3'd2,
      S_FEED   = 3'd3,
      S_FLUSH  = 3'd4,
      S_DRAIN  = 3'd5,
      S_DONE   = 3'd6
   } state_e;

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [RW-1:0] row_q, row_d;
   logic [KW-1:0] k_len_q, k_len_d;
   logic [CW-1:0] k_last;
   logic          freeze;
   logic          frozen_d;

   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          sclr_q, sclr_d;
   logic          compute_q, compute_d;
   logic          w_load_q, w_load_d;
   logic [RW-1:0] w_row_sel_q, w_row_sel_d;
   logic          f_rd_en_q, f_rd_en_d;
   logic [KW-1:0] f_rd_addr_q, f_rd_addr_d;
   logic          out_valid_q, out_valid_d;
   logic [RW-1:0] out_row_q, out_row_d;

`ifdef SA_PAUSE_EN
   assign freeze = bus.pause;
`else
   logic pause_unused;
   assign pause_unused = bus.pause;
   assign freeze       = 1'b0;
`endif

   // FEED only runs with k_len_q >= 1, so the subtraction never underflows there.
   assign k_last = CW'(k_len_q) - CW'(1);

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      row_d    = row_q;
      k_len_d  = k_len_q;
      frozen_d = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               state_d = S_CLEAR;
               k_len_d = bus.k_len;
               cnt_d   = '0;
               row_d   = '0;
            end
         end
         S_CLEAR: begin
            state_d = S_LOAD_W;
            cnt_d   = '0;
         end
         S_LOAD_W: begin
            if (cnt_q == CW'(ROWS - 1)) begin
               cnt_d   = '0;
               state_d = (k_len_q == '0) ? S_DONE : S_FEED;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_FEED: begin
            if (freeze) begin
               frozen_d = 1'b1;
            end else if (cnt_q == k_last) begin
               cnt_d   = '0;
               row_d   = '0;
               state_d = (FLUSH_LEN == 0) ? S_DRAIN : S_FLUSH;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_FLUSH: begin
            if (freeze) begin
               frozen_d = 1'b1;
            end else if (cnt_q == CW'(FLUSH_LEN - 1)) begin
               cnt_d   = '0;
               row_d   = '0;
               state_d = S_DRAIN;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         // out_valid is high for the whole of DRAIN, so a transfer happens on
         // exactly the cycles where out_ready is sampled high.
         S_DRAIN: begin
            if (bus.out_ready) begin
               if (row_q == RW'(ROWS - 1)) state_d = S_DONE;
               else                        row_d   = row_q + RW'(1);
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      busy_d      = (state_d != S_IDLE);
      done_d      = (state_d == S_DONE);
      sclr_d      = (state_d == S_CLEAR);
      w_load_d    = (state_d == S_LOAD_W);
      w_row_sel_d = w_load_d ? cnt_d[RW-1:0] : '0;
      compute_d   = ((state_d == S_FEED) || (state_d == S_FLUSH)) && !frozen_d;
      f_rd_en_d   = (state_d == S_FEED) && !frozen_d;
      f_rd_addr_d = (state_d == S_FEED) ? cnt_d[KW-1:0] : '0;
      out_valid_d = (state_d == S_DRAIN);
      out_row_d   = out_valid_d ? row_d : '0;
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         row_q       <= '0;
         k_len_q     <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         sclr_q      <= 1'b0;
         compute_q   <= 1'b0;
         w_load_q    <= 1'b0;
         w_row_sel_q <= '0;
         f_rd_en_q   <= 1'b0;
         f_rd_addr_q <= '0;
         out_valid_q <= 1'b0;
         out_row_q   <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         row_q       <= row_d;
         k_len_q     <= k_len_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         sclr_q      <= sclr_d;
         compute_q   <= compute_d;
         w_load_q    <= w_load_d;
         w_row_sel_q <= w_row_sel_d;
         f_rd_en_q   <= f_rd_en_d;
         f_rd_addr_q <= f_rd_addr_d;
         out_valid_q <= out_valid_d;
         out_row_q   <= out_row_d;
      end
   end

   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
   assign bus.sclr       = sclr_q;
   assign bus.compute_sa = compute_q;
   assign bus.w_load     = w_load_q;
   assign bus.w_row_sel  = w_row_sel_q;
   assign bus.f_rd_en    = f_rd_en_q;
   assign bus.f_rd_addr  = f_rd_addr_q;
   assign bus.out_valid  = out_valid_q;
   assign bus.out_row    = out_row_q;
   assign dbg_state_o    = state_q;
endmodule

// File: tb/tb_sa_controller.sv
// Bench for sa_controller: per-cycle output trace compared against a phase-list
// model of a tile built from k_len and the out_ready/pause patterns.
module tb_sa_controller;
   localparam int ROWS = 4;
   localparam int COLS = 4;
   localparam int KW   = 8;
   localparam int RW   = $clog2(ROWS);
   localparam int FL   = ROWS + COLS - 2;
   localparam int W    = 7 + 2 * RW + KW;
   localparam int MAXC = 400;

   logic       Clk = 1'b0;
   logic       Rst_n = 1'b0;
   logic [2:0] dbg_state;

   int errors = 0;
   int checks = 0;

   bit ready_a [MAXC];
   bit pause_a [MAXC];
   logic [W-1:0] exp_q [$];

   sa_controller_if #(.ROWS(ROWS), .KW(KW)) bus ();

   sa_controller #(.ROWS(ROWS), .COLS(COLS), .KW(KW)) dut (
      .Clk         (Clk),
      .Rst_n       (Rst_n),
      .bus         (bus.slave),
      .dbg_state_o (dbg_state)
   );

   // clock
   always #5 Clk = ~Clk;

   function automatic logic [W-1:0] rec(input logic busy, input logic done,
                                        input logic sclr, input logic comp,
                                        input logic wl, input logic [RW-1:0] wsel,
                                        input logic fen, input logic [KW-1:0] fa,
                                        input logic ov, input logic [RW-1:0] orow);
      return {busy, done, sclr, comp, wl, wsel, fen, fa, ov, orow};
   endfunction

   function automatic logic [W-1:0] observed();
      return {bus.busy, bus.done, bus.sclr, bus.compute_sa, bus.w_load, bus.w_row_sel,
              bus.f_rd_en, bus.f_rd_addr, bus.out_valid, bus.out_row};
   endfunction

   task automatic check(input string tag, input int c, input logic [W-1:0] obs,
                        input logic [W-1:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s c=%0d: observed=%h expected=%h", tag, c, obs, exp_v);
      end
   endtask

   task automatic fill_patterns(input int ready_pct, input int pause_pct);
      for (int i = 0; i < MAXC; i++) begin
         ready_a[i] = ($urandom_range(0, 99) < ready_pct);
         pause_a[i] = ($urandom_range(0, 99) < pause_pct);
      end
   endtask

   // Expected trace of one tile, indexed by cycle: cycle 0 is the idle cycle in
   // which start is presented, the last entry is the done cycle.
   task automatic build_tile(input int k);
      int row;
      bit fin;
      bit fe;
      logic [KW-1:0] fa;
      exp_q.delete();
      exp_q.push_back('0);
      exp_q.push_back(rec(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, '0));
      for (int r = 0; r < ROWS; r++)
         exp_q.push_back(rec(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, RW'(r), 1'b0, '0, 1'b0, '0));
      if (k > 0) begin
         for (int a = 0; a < k + FL; a++) begin
            fe = (a < k);
            fa = fe ? KW'(a) : '0;
            exp_q.push_back(rec(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, '0, fe, fa, 1'b0, '0));
`ifdef SA_PAUSE_EN
            while (pause_a[exp_q.size() - 1] && exp_q.size() < MAXC - 2)
               exp_q.push_back(rec(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, fa, 1'b0, '0));
`endif
         end
         row = 0;
         fin = 1'b0;
         while (!fin && exp_q.size() < MAXC - 2) begin
            exp_q.push_back(rec(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0, 1'b1, RW'(row)));
            if (ready_a[exp_q.size() - 1]) begin
               if (row == ROWS - 1) fin = 1'b1;
               else                 row++;
            end
         end
      end
      exp_q.push_back(rec(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, '0));
   endtask

   // Entered and left #1 after a rising edge; start is presented in cycle 0.
   task automatic run_tile(input string tag, input int k, input bit hold_start);
      int n;
      logic [W-1:0] exp_v;
      build_tile(k);
      n = exp_q.size();
      for (int c = 0; c < n; c++) begin
         bus.start     = (c == 0) || hold_start;
         bus.k_len     = (c == 0) ? KW'(k) : KW'($urandom);
         bus.out_ready = ready_a[c];
         bus.pause     = pause_a[c];
         @(negedge Clk);
         exp_v = exp_q.pop_front();
         check(tag, c, observed(), exp_v);
         @(posedge Clk);
         #1;
      end
      bus.start = 1'b0;
   endtask

   initial begin
      bus.start     = 1'b0;
      bus.k_len     = '0;
      bus.pause     = 1'b0;
      bus.out_ready = 1'b0;

      // reset state
      #2;
      check("reset_outputs", 0, observed(), '0);
      check("reset_state", 0, W'(dbg_state), '0);
      @(negedge Clk);
      Rst_n = 1'b1;
      @(posedge Clk);
      #1;

      // nominal
      fill_patterns(100, 0);
      run_tile("nominal", 5, 1'b0);

      // backpressure on cycles 18-19
      fill_patterns(100, 0);
      ready_a[18] = 1'b0;
      ready_a[19] = 1'b0;
      run_tile("backpressure", 5, 1'b0);

      // empty reduction
      fill_patterns(100, 0);
      run_tile("k_zero", 0, 1'b0);

      // pause on cycles 8-9 (nominal timing when the feature is compiled out)
      fill_patterns(100, 0);
      pause_a[8] = 1'b1;
      pause_a[9] = 1'b1;
      run_tile("pause", 5, 1'b0);

      // start held for a whole tile, then re-sampled in IDLE
      fill_patterns(100, 0);
      run_tile("held_start_a", 3, 1'b1);
      run_tile("held_start_b", 2, 1'b0);

      // reset in the middle of FEED
      fill_patterns(100, 0);
      bus.start     = 1'b1;
      bus.k_len     = KW'(5);
      bus.out_ready = 1'b1;
      @(posedge Clk);
      #1;
      bus.start = 1'b0;
      repeat (7) @(posedge Clk);
      @(negedge Clk);
      check("pre_reset_feed", 8, observed(),
            rec(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b1, KW'(2), 1'b0, '0));
      #1;
      Rst_n = 1'b0;
      #1;
      check("async_reset", 8, observed(), '0);
      check("async_reset_state", 8, W'(dbg_state), '0);
      for (int i = 0; i < 3; i++) begin
         @(negedge Clk);
         check("held_reset", 9 + i, observed(), '0);
      end
      Rst_n = 1'b1;
      @(posedge Clk);
      #1;
      run_tile("after_reset", 5, 1'b0);

      // randomized tiles
      for (int t = 0; t < 10; t++) begin
         fill_patterns(70, 25);
         run_tile("random", $urandom_range(0, 12), 1'($urandom_range(0, 1)));
      end

      // longest reduction
      fill_patterns(100, 0);
      run_tile("k_max", (1 << KW) - 1, 1'b0);

      // report
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
